// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the data memory controller and its channels.
package gpu_mem_pkg;

  localparam int DEF_ADDR_BITS     = 12;
  localparam int DEF_DATA_BITS     = 16;
  localparam int DEF_NUM_CONSUMERS = 16;
  localparam int DEF_NUM_CHANNELS  = 4;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_READ_WAITING,
    CH_WRITE_WAITING,
    CH_READ_RELAYING,
    CH_WRITE_RELAYING
  } ch_state_e;

endpackage

// File: rtl/mem_channel_fsm.sv
// One memory channel: captures a granted request, runs the memory handshake,
// then relays the result to the owning consumer until it drops its request.
module mem_channel_fsm
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int IDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant,
  input  logic [IDX_BITS-1:0]  grant_idx,
  input  logic                 grant_is_read,
  input  logic [ADDR_BITS-1:0] grant_addr,
  input  logic [DATA_BITS-1:0] grant_data,
  input  logic                 owner_valid,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_ready,
  output logic                 idle,
  output logic                 read_relaying,
  output logic                 write_relaying,
  output logic                 release_claim,
  output logic [IDX_BITS-1:0]  owner,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data
);

  ch_state_e              state_q, state_d;
  logic [IDX_BITS-1:0]    owner_q, owner_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic                   mem_rv_q, mem_rv_d;
  logic                   mem_wv_q, mem_wv_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_rv_d = mem_rv_q;
    mem_wv_d = mem_wv_q;
    case (state_q)
      CH_IDLE: begin
        if (grant) begin
          owner_d = grant_idx;
          addr_d  = grant_addr;
          if (grant_is_read) begin
            state_d  = CH_READ_WAITING;
            mem_rv_d = 1'b1;
          end else begin
            state_d  = CH_WRITE_WAITING;
            wdata_d  = grant_data;
            mem_wv_d = 1'b1;
          end
        end
      end
      CH_READ_WAITING: begin
        if (mem_read_ready) begin
          rdata_d  = mem_read_data;
          mem_rv_d = 1'b0;
          state_d  = CH_READ_RELAYING;
        end
      end
      CH_WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_wv_d = 1'b0;
          state_d  = CH_WRITE_RELAYING;
        end
      end
      CH_READ_RELAYING, CH_WRITE_RELAYING: begin
        // Memory ready is ignored here; only the consumer dropping its request ends the relay.
        if (!owner_valid) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CH_IDLE;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_rv_q <= 1'b0;
      mem_wv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_rv_q <= mem_rv_d;
      mem_wv_q <= mem_wv_d;
    end
  end

  assign idle              = (state_q == CH_IDLE);
  assign read_relaying     = (state_q == CH_READ_RELAYING);
  assign write_relaying    = (state_q == CH_WRITE_RELAYING);
  assign release_claim     = (read_relaying || write_relaying) && !owner_valid;
  assign owner             = owner_q;
  assign read_data         = rdata_q;
  assign mem_read_valid    = mem_rv_q;
  assign mem_read_address  = addr_q;
  assign mem_write_valid   = mem_wv_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: rtl/data_mem_controller.sv
// Multiplexes many LSU consumers onto a few memory channels with round-robin
// arbitration; each claimed consumer is served end-to-end by one channel.
module data_mem_controller
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
  logic [IDX_BITS-1:0]      rr_q, rr_d;
  logic [NUM_CONSUMERS-1:0] pending, taken, release_mask;

  logic [NUM_CHANNELS-1:0]  ch_idle, ch_grant, ch_grant_is_read, ch_owner_valid;
  logic [NUM_CHANNELS-1:0]  ch_read_relaying, ch_write_relaying, ch_release;
  logic [IDX_BITS-1:0]      ch_grant_idx [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      ch_owner     [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]     ch_grant_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     ch_grant_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]     ch_read_data  [NUM_CHANNELS];

  int  idx;
  int  last_grant;
  logic any_grant;

  assign pending = consumer_read_valid | consumer_write_valid;

  // Idle channels take turns in ascending order; each skips consumers already claimed or taken this cycle.
  always_comb begin
    taken      = claim_q;
    ch_grant   = '0;
    idx        = 0;
    last_grant = int'(rr_q);
    any_grant  = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) ch_grant_idx[c] = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_idle[c]) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx = int'(rr_q) + k;
          if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
          if (!ch_grant[c] && pending[idx] && !taken[idx]) begin
            ch_grant[c]     = 1'b1;
            ch_grant_idx[c] = idx[IDX_BITS-1:0];
            taken[idx]      = 1'b1;
            last_grant      = idx;
            any_grant       = 1'b1;
          end
        end
      end
    end
    rr_d = rr_q;
    if (any_grant) begin
      rr_d = (last_grant == NUM_CONSUMERS - 1) ? '0 : IDX_BITS'(last_grant + 1);
    end
  end

  always_comb begin
    release_mask = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_release[c]) release_mask[ch_owner[c]] = 1'b1;
    end
    claim_d = (claim_q & ~release_mask) | (taken & ~claim_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      claim_q <= '0;
      rr_q    <= '0;
    end else begin
      claim_q <= claim_d;
      rr_q    <= rr_d;
    end
  end

  // Consumer-side outputs decode from registered channel state only.
  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_read_relaying[c]) begin
        consumer_read_ready[ch_owner[c]] = 1'b1;
        consumer_read_data[int'(ch_owner[c])*DATA_BITS +: DATA_BITS] = ch_read_data[c];
      end
      if (ch_write_relaying[c]) consumer_write_ready[ch_owner[c]] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
      assign ch_grant_is_read[gi] = consumer_read_valid[ch_grant_idx[gi]];
      assign ch_grant_addr[gi] = ch_grant_is_read[gi]
          ? consumer_read_address[int'(ch_grant_idx[gi])*ADDR_BITS +: ADDR_BITS]
          : consumer_write_address[int'(ch_grant_idx[gi])*ADDR_BITS +: ADDR_BITS];
      assign ch_grant_data[gi] = consumer_write_data[int'(ch_grant_idx[gi])*DATA_BITS +: DATA_BITS];
      assign ch_owner_valid[gi] = ch_read_relaying[gi] ? consumer_read_valid[ch_owner[gi]]
                                                       : consumer_write_valid[ch_owner[gi]];

      mem_channel_fsm #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .IDX_BITS (IDX_BITS)
      ) u_channel (
        .clk              (clk),
        .reset            (reset),
        .grant            (ch_grant[gi]),
        .grant_idx        (ch_grant_idx[gi]),
        .grant_is_read    (ch_grant_is_read[gi]),
        .grant_addr       (ch_grant_addr[gi]),
        .grant_data       (ch_grant_data[gi]),
        .owner_valid      (ch_owner_valid[gi]),
        .mem_read_ready   (mem_read_ready[gi]),
        .mem_read_data    (mem_read_data[gi*DATA_BITS +: DATA_BITS]),
        .mem_write_ready  (mem_write_ready[gi]),
        .idle             (ch_idle[gi]),
        .read_relaying    (ch_read_relaying[gi]),
        .write_relaying   (ch_write_relaying[gi]),
        .release_claim    (ch_release[gi]),
        .owner            (ch_owner[gi]),
        .read_data        (ch_read_data[gi]),
        .mem_read_valid   (mem_read_valid[gi]),
        .mem_read_address (mem_read_address[gi*ADDR_BITS +: ADDR_BITS]),
        .mem_write_valid  (mem_write_valid[gi]),
        .mem_write_address(mem_write_address[gi*ADDR_BITS +: ADDR_BITS]),
        .mem_write_data   (mem_write_data[gi*DATA_BITS +: DATA_BITS])
      );
    end
  endgenerate

endmodule
